io_port_bridge: RTL and testbench
=================================

Name: io_port_bridge

Overview:
- Peripheral on the far side of the 8-bit datapath's IN/OUT instructions.
- Captures bytes the datapath drives on its output port during OUT (op 4'b0110) into a TX FIFO, then hands them to an external device over a valid/ready stream.
- Buffers bytes arriving from the external device in an RX FIFO and presents the head byte as the datapath's input port for IN (op 4'b0111).
- Drives a stall so the controller holds the instruction while the needed FIFO is full or empty.

Parameters:
- DEPTH, 4: entries per FIFO; power of two, 2..16.
- DATA_W, 8: byte width; fixed to the datapath width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- op  input  4  current instruction opcode from the controller
- cpu_out  input  DATA_W  byte driven by the datapath output port, valid when op==OUT
- cpu_in  output  DATA_W  byte to the datapath input port
- stall  output  1  hold current instruction
- tx_data  output  DATA_W  byte to external device
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  external device accepts
- rx_data  input  DATA_W  byte from external device
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  bridge can accept rx_data

Behaviour:
- Reset is asynchronous and active-high on rst. Both FIFOs are emptied and pointers zeroed.
- Reset values: tx_valid=0, rx_ready=1, stall=0, cpu_in=0, tx_data=0. Memory contents are don't-care, but every output is forced to 0 while its FIFO is empty.
- TX push: at a clk edge with op==OUT and the TX FIFO not full, write cpu_out. The byte appears on tx_data/tx_valid the next cycle (1-cycle latency).
- TX pop: at a clk edge with tx_valid && tx_ready, advance the read pointer.
  - tx_data holds stable while tx_valid=1 and tx_ready=0.
- TX full plus op==OUT: stall=1 combinationally and no write. A push and a pop in the same cycle on a full FIFO is not allowed, because stall is computed from the count alone.
- RX push: at a clk edge with rx_valid && rx_ready, write rx_data.
  - rx_ready = !rx_full, registered-count based, so it does not depend on a same-cycle pop.
- RX pop:
  - cpu_in = RX head (combinational from memory) when not empty, else 0.
  - At a clk edge with op==IN and the RX FIFO not empty, advance the read pointer. The datapath latches cpu_in on the same edge.
  - op==IN with RX empty gives stall=1. A byte pushed that cycle is visible next cycle; stall then drops.
- stall = (op==OUT && tx_full) || (op==IN && rx_empty). Any other op gives stall=0 and no FIFO access.
- Counts: each FIFO keeps a (log2(DEPTH)+1)-bit count. Pointers wrap modulo DEPTH. A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Asserting rst mid-transfer discards all buffered bytes immediately. tx_valid drops asynchronously.

Optional Feature:
- Macro IO_PORT_STATUS_EN.
- When defined: adds output io_status[3:0] = {tx_full, tx_empty, rx_full, rx_empty}, registered, reset value 4'b0101. Also adds a sticky output rx_drop, set when rx_valid=1 while rx_ready=0 and cleared only by rst.
- When undefined: neither port exists and behaviour is otherwise identical.

Decomposition:
- Package io_pkg holds:
  - localparams OP_OUT=4'b0110, OP_IN=4'b0111, DATA_W=8
  - the status bit-index constants
- One sub-module, io_fifo (parameters DEPTH, DATA_W), instantiated twice. It has push, pop, wdata, rdata, full, empty and count ports.

Test Plan:
- Reset: assert rst mid-cycle -> tx_valid=0, rx_ready=1, stall=0, cpu_in=0 without waiting for a clock edge.
- TX path: op=OUT with cpu_out=8'hA5, then 8'h3C, tx_ready=1 -> tx_data=A5 one cycle after the first push, then 3C. Ordering is preserved.
- TX full: tx_ready=0, issue 4 OUTs (8'h01..04) -> fifth OUT gives stall=1. Raise tx_ready -> stall drops the cycle after the first pop, and 8'h05 is accepted.
- RX path: push rx_data=8'h7E -> cpu_in=7E. op=IN pops it, and cpu_in returns to 0.
- RX empty: op=IN with no data -> stall=1. Push 8'h42 -> stall=0 next cycle and cpu_in=42.
- Wrap: stream 10 bytes through each FIFO with random ready/valid -> data matches the reference queue and pointers wrap correctly.

Source files
------------

// File: rtl/io_pkg.sv
// Shared opcodes, datapath width and status bit positions for the IN/OUT port bridge.
package io_pkg;
  localparam logic [3:0] OP_OUT = 4'b0110;
  localparam logic [3:0] OP_IN  = 4'b0111;
  localparam int DATA_W = 8;

  localparam int ST_TX_FULL  = 3;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_RX_EMPTY = 0;
endpackage

// File: rtl/io_port_bridge_if.sv
// Controller-side IN/OUT signals plus the TX/RX byte streams to the external device.
// Status signals exist only when IO_PORT_STATUS_EN is defined.
interface io_port_bridge_if #(
  parameter int DATA_W = io_pkg::DATA_W
);
  logic [3:0]        op;
  logic [DATA_W-1:0] cpu_out;
  logic [DATA_W-1:0] cpu_in;
  logic              stall;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
`ifdef IO_PORT_STATUS_EN
  logic [3:0]        io_status;
  logic              rx_drop;

  modport master (
    output op, cpu_out, tx_ready, rx_data, rx_valid,
    input  cpu_in, stall, tx_data, tx_valid, rx_ready, io_status, rx_drop
  );
  modport slave (
    input  op, cpu_out, tx_ready, rx_data, rx_valid,
    output cpu_in, stall, tx_data, tx_valid, rx_ready, io_status, rx_drop
  );
`else
  modport master (
    output op, cpu_out, tx_ready, rx_data, rx_valid,
    input  cpu_in, stall, tx_data, tx_valid, rx_ready
  );
  modport slave (
    input  op, cpu_out, tx_ready, rx_data, rx_valid,
    output cpu_in, stall, tx_data, tx_valid, rx_ready
  );
`endif
endinterface

// File: rtl/io_port_bridge_fifo.sv
// Small synchronous FIFO: count-based full/empty, head byte read combinationally (0 when empty).
module io_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointers are exactly AW bits wide, so incrementing wraps modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/io_port_bridge.sv
// IN/OUT port bridge: OUT bytes queue to a TX stream, RX stream bytes feed IN, stall on full/empty.
// Define IO_PORT_STATUS_EN to add the registered io_status flags and sticky rx_drop.
module io_port_bridge #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input logic             clk,
  input logic             rst,
  io_port_bridge_if.slave bus
);
  import io_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic              tx_full;
  logic              tx_empty;
  logic              rx_full;
  logic              rx_empty;
  logic [CW-1:0]     tx_count;
  logic [CW-1:0]     rx_count;
  logic [DATA_W-1:0] tx_head;
  logic [DATA_W-1:0] rx_head;
  logic              is_out;
  logic              is_in;

  assign is_out = (bus.op == OP_OUT);
  assign is_in  = (bus.op == OP_IN);

  // Push/pop requests are gated on full/empty inside each FIFO.
  io_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (is_out),
    .pop   (bus.tx_ready),
    .wdata (bus.cpu_out),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  io_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.rx_valid),
    .pop   (is_in),
    .wdata (bus.rx_data),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign bus.tx_data  = tx_head;
  assign bus.tx_valid = !tx_empty;
  assign bus.rx_ready = !rx_full;
  assign bus.cpu_in   = rx_head;
  assign bus.stall    = (is_out && tx_full) || (is_in && rx_empty);

  ap_count_bound: assert property (@(posedge clk) disable iff (rst)
    (tx_count <= CW'(DEPTH)) && (rx_count <= CW'(DEPTH)));

`ifdef IO_PORT_STATUS_EN
  logic [3:0] status_q;
  logic       drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= 4'b0101;
      drop_q   <= 1'b0;
    end else begin
      status_q[ST_TX_FULL]  <= tx_full;
      status_q[ST_TX_EMPTY] <= tx_empty;
      status_q[ST_RX_FULL]  <= rx_full;
      status_q[ST_RX_EMPTY] <= rx_empty;
      if (bus.rx_valid && rx_full) drop_q <= 1'b1;
    end
  end

  assign bus.io_status = status_q;
  assign bus.rx_drop   = drop_q;
`endif
endmodule

// File: tb/tb_io_port_bridge.sv
// Directed plus randomized-handshake bench for io_port_bridge with a queue scoreboard per FIFO.
module tb_io_port_bridge;
  import io_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [3:0] OP_NOP = 4'b0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_port_bridge_if #(.DATA_W(8)) bus ();

  io_port_bridge #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit last_tx_acc;
  bit last_rx_acc;

  int         tx_i;
  int         rx_i;
  logic [3:0] r_op;
  logic [7:0] r_co;
  logic [7:0] r_rd;
  logic       r_tr;
  logic       r_rv;
  bit         done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string pfx);
    chk({pfx, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
    chk({pfx, "_tx_data"},  32'(bus.tx_data),  32'd0);
    chk({pfx, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
    chk({pfx, "_stall"},    32'(bus.stall),    32'd0);
    chk({pfx, "_cpu_in"},   32'(bus.cpu_in),   32'd0);
  endtask

  // One clock: drive, compare every output against the scoreboard, then advance the model.
  task automatic step(input logic [3:0] op, input logic [7:0] co, input logic tr,
                      input logic rv, input logic [7:0] rd);
    bit exp_stall;
    bit tx_pop;
    bit rx_pop;
    bus.op       = op;
    bus.cpu_out  = co;
    bus.tx_ready = tr;
    bus.rx_valid = rv;
    bus.rx_data  = rd;
    #1;
    exp_stall = (op == OP_OUT && txq.size() == DEPTH) || (op == OP_IN && rxq.size() == 0);
    chk("stall",    32'(bus.stall),    32'(exp_stall));
    chk("tx_valid", 32'(bus.tx_valid), 32'(txq.size() != 0));
    chk("tx_data",  32'(bus.tx_data),  (txq.size() != 0) ? 32'(txq[0]) : 32'd0);
    chk("rx_ready", 32'(bus.rx_ready), 32'(rxq.size() < DEPTH));
    chk("cpu_in",   32'(bus.cpu_in),   (rxq.size() != 0) ? 32'(rxq[0]) : 32'd0);
    last_tx_acc = (op == OP_OUT) && (txq.size() < DEPTH);
    tx_pop      = tr && (txq.size() != 0);
    last_rx_acc = rv && (rxq.size() < DEPTH);
    rx_pop      = (op == OP_IN) && (rxq.size() != 0);
    @(posedge clk);
    #1;
    if (tx_pop) void'(txq.pop_front());
    if (last_tx_acc) txq.push_back(co);
    if (rx_pop) void'(rxq.pop_front());
    if (last_rx_acc) rxq.push_back(rd);
  endtask

  initial begin
    bus.op       = OP_NOP;
    bus.cpu_out  = 8'h00;
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset values, observed before any clock edge.
    #3;
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // TX path ordering and 1-cycle latency.
    step(OP_OUT, 8'hA5, 1'b1, 1'b0, 8'h00);
    chk("tx_first_push", 32'(bus.tx_data), 32'hA5);
    step(OP_OUT, 8'h3C, 1'b1, 1'b0, 8'h00);
    chk("tx_second", 32'(bus.tx_data), 32'h3C);
    step(OP_NOP, 8'h00, 1'b1, 1'b0, 8'h00);
    step(OP_NOP, 8'h00, 1'b1, 1'b0, 8'h00);

    // TX full: four OUTs fill it, fifth stalls until a pop frees a slot.
    for (int i = 1; i <= 4; i++) step(OP_OUT, 8'(i), 1'b0, 1'b0, 8'h00);
    step(OP_OUT, 8'h05, 1'b0, 1'b0, 8'h00);
    chk("tx_full_no_accept", 32'(last_tx_acc), 32'd0);
    step(OP_OUT, 8'h05, 1'b1, 1'b0, 8'h00);
    step(OP_OUT, 8'h05, 1'b1, 1'b0, 8'h00);
    chk("tx_05_accepted", 32'(last_tx_acc), 32'd1);
    for (int i = 0; i < 5; i++) step(OP_NOP, 8'h00, 1'b1, 1'b0, 8'h00);

    // RX path.
    step(OP_NOP, 8'h00, 1'b0, 1'b1, 8'h7E);
    chk("rx_head_7e", 32'(bus.cpu_in), 32'h7E);
    step(OP_IN, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("rx_after_pop", 32'(bus.cpu_in), 32'h00);

    // RX empty stall, released the cycle after a push.
    step(OP_IN, 8'h00, 1'b0, 1'b1, 8'h42);
    bus.op = OP_IN;
    bus.rx_valid = 1'b0;
    #1;
    chk("rx_stall_drop", 32'(bus.stall), 32'd0);
    chk("rx_head_42", 32'(bus.cpu_in), 32'h42);
    step(OP_IN, 8'h00, 1'b0, 1'b0, 8'h00);
    step(OP_NOP, 8'h00, 1'b0, 1'b0, 8'h00);

    // Ten bytes each way with random handshakes, forcing pointer wrap.
    tx_i = 0;
    rx_i = 0;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (tx_i < 10 && $urandom_range(0, 1) == 1) r_op = OP_OUT;
      else if ($urandom_range(0, 2) != 0)         r_op = OP_IN;
      else                                        r_op = OP_NOP;
      r_co = 8'($urandom);
      r_rd = 8'($urandom);
      r_tr = 1'($urandom_range(0, 1));
      r_rv = (rx_i < 10) && ($urandom_range(0, 1) == 1);
      step(r_op, r_co, r_tr, r_rv, r_rd);
      if (last_tx_acc) tx_i++;
      if (last_rx_acc) rx_i++;
      done = (tx_i == 10) && (rx_i == 10) && (txq.size() == 0) && (rxq.size() == 0);
    end
    chk("wrap_done", 32'(done), 32'd1);

    // Reset mid-transfer discards everything without a clock edge.
    for (int i = 0; i < 3; i++) step(OP_OUT, 8'(8'h90 + i), 1'b0, 1'b1, 8'(8'h60 + i));
    bus.op = OP_NOP;
    bus.rx_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    txq.delete();
    rxq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(OP_NOP, 8'h00, 1'b1, 1'b0, 8'h00);
    step(OP_IN, 8'h00, 1'b1, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
